// File: rtl/dmem_bytectl_if.sv
// Request/response bundle for dmem_bytectl: valid/ready request channel, strobe-only response channel.
interface dmem_bytectl_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W+1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy_clear;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy_clear
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy_clear
  );
endinterface

// File: rtl/dmem_bytectl.sv
// Byte-addressed data memory: lane-masked stores, extended sub-word loads, self-clear after reset.
// Every accepted request answers exactly RD_LAT cycles later; req_ready low while clearing, no response backpressure.
module dmem_bytectl #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  dmem_bytectl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [31:0]       mem_arr [DEPTH];

  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0] pipe_err_q, pipe_err_d;
  logic [31:0]       pipe_dat_q [RD_LAT];
  logic [31:0]       pipe_dat_d [RD_LAT];

  logic              req_rdy;
  logic              accept;
  logic              misalign;
  logic [1:0]        offset;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       ld_dat;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_idx;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdat;

  assign offset   = bus.req_addr[1:0];
  assign word_idx = bus.req_addr[ADDR_W+1:2];
  // Requests seen in the reset cycle are dropped even if the FSM was running.
  assign req_rdy  = (state_q == ST_RUN) && !rst;
  assign accept   = bus.req_valid && req_rdy;
  assign rd_word  = mem_arr[word_idx];

  always_comb begin
    misalign = 1'b1;
    case (bus.req_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = offset[0];
      2'b10:   misalign = (offset != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel = rd_word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];
    ld_dat   = rd_word;
    case (bus.req_size)
      2'b00:   ld_dat = bus.req_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   ld_dat = bus.req_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ld_dat = rd_word;
    endcase
  end

  // Single write port shared between the clear sweep and accepted stores.
  always_comb begin
    mem_we   = 1'b0;
    mem_idx  = word_idx;
    mem_be   = 4'b0000;
    mem_wdat = 32'h0;
    if (state_q == ST_CLEAR) begin
      mem_we   = !rst;
      mem_idx  = clr_cnt_q;
      mem_be   = 4'b1111;
      mem_wdat = 32'h0;
    end else if (accept && bus.req_we && !misalign) begin
      mem_we = 1'b1;
      case (bus.req_size)
        2'b00: begin
          mem_be   = 4'b0001 << offset;
          mem_wdat = {4{bus.req_wdata[7:0]}};
        end
        2'b01: begin
          mem_be   = offset[1] ? 4'b1100 : 4'b0011;
          mem_wdat = {2{bus.req_wdata[15:0]}};
        end
        default: begin
          mem_be   = 4'b1111;
          mem_wdat = bus.req_wdata;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && mem_be[b]) begin
        mem_arr[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == {ADDR_W{1'b1}}) begin
        state_d = ST_RUN;
      end
    end
  end

  // Stage 0 holds the extended load result; stores and errors carry zero data.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_err_d    = '0;
    pipe_dat_d    = pipe_dat_q;
    pipe_vld_d[0] = accept;
    pipe_err_d[0] = accept && misalign;
    pipe_dat_d[0] = (accept && !bus.req_we && !misalign) ? ld_dat : 32'h0;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_err_d[i] = pipe_err_q[i-1];
      pipe_dat_d[i] = pipe_dat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_dat_q[i] <= 32'h0;
      end
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_err_q <= pipe_err_d;
      pipe_dat_q <= pipe_dat_d;
    end
  end

  assign bus.req_ready  = req_rdy;
  assign bus.rsp_valid  = pipe_vld_q[RD_LAT-1];
  assign bus.rsp_err    = pipe_err_q[RD_LAT-1];
  assign bus.rsp_rdata  = pipe_dat_q[RD_LAT-1];
  assign bus.busy_clear = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_dmem_bytectl.sv
// Directed bench: three dmem_bytectl instances (RD_LAT 1, 3, 4; 16 words) share one stimulus stream.
// Each response is checked against a hand-computed expectation at its accept cycle plus RD_LAT.
module tb_dmem_bytectl;
  localparam int AW = 4;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_valid;
  logic          d_we;
  logic [AW+1:0] d_addr;
  logic [1:0]    d_size;
  logic          d_uns;
  logic [31:0]   d_wdata;

  logic [NI-1:0] rdy_v, vld_v, err_v, busy_v;
  logic [31:0]   dat_v [NI];

  int cyc = 0;
  int n_vec = 0;
  int n_mis = 0;
  int n_tmo = 0;
  bit drain_req = 1'b0;

  int          exp_cyc [$];
  logic [31:0] exp_dat [$];
  bit          exp_err [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_bytectl_if #(.ADDR_W(AW)) bif ();
    assign bif.req_valid    = d_valid;
    assign bif.req_we       = d_we;
    assign bif.req_addr     = d_addr;
    assign bif.req_size     = d_size;
    assign bif.req_unsigned = d_uns;
    assign bif.req_wdata    = d_wdata;
    assign rdy_v[g]  = bif.req_ready;
    assign vld_v[g]  = bif.rsp_valid;
    assign err_v[g]  = bif.rsp_err;
    assign busy_v[g] = bif.busy_clear;
    assign dat_v[g]  = bif.rsp_rdata;

    dmem_bytectl #(.ADDR_W(AW), .RD_LAT((g == 0) ? 1 : g + 2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  int  ptr   [NI];
  int  bcnt  [NI];
  bit  armed [NI];
  bit  started = 1'b0;
  bit  drained = 1'b0;
  int  lat;

  // Sole checker process; sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      started = 1'b1;
      for (int i = 0; i < NI; i++) begin
        ptr[i]   = exp_cyc.size();
        bcnt[i]  = 0;
        armed[i] = 1'b1;
      end
    end else if (started) begin
      for (int i = 0; i < NI; i++) begin
        lat = (i == 0) ? 1 : i + 2;
        if (busy_v[i]) begin
          bcnt[i]++;
          chk($sformatf("L%0d ready_in_clear", lat), 32'(rdy_v[i]), 32'd0);
        end else begin
          if (armed[i]) begin
            chk($sformatf("L%0d clear_cycles", lat), bcnt[i], 32'd16);
            armed[i] = 1'b0;
          end
          chk($sformatf("L%0d ready_in_run", lat), 32'(rdy_v[i]), 32'd1);
        end
        if (ptr[i] < exp_cyc.size() && exp_cyc[ptr[i]] + lat == cyc) begin
          chk($sformatf("L%0d vec%0d rsp_valid", lat, ptr[i]), 32'(vld_v[i]), 32'd1);
          chk($sformatf("L%0d vec%0d rsp_rdata", lat, ptr[i]), dat_v[i], exp_dat[ptr[i]]);
          chk($sformatf("L%0d vec%0d rsp_err", lat, ptr[i]), 32'(err_v[i]), 32'(exp_err[ptr[i]]));
          ptr[i]++;
        end else begin
          chk($sformatf("L%0d idle rsp_valid c%0d", lat, cyc), 32'(vld_v[i]), 32'd0);
          chk($sformatf("L%0d idle rsp_rdata c%0d", lat, cyc), dat_v[i], 32'd0);
          chk($sformatf("L%0d idle rsp_err c%0d", lat, cyc), 32'(err_v[i]), 32'd0);
        end
        if (drain_req && !drained) begin
          chk($sformatf("L%0d responses_seen", lat), ptr[i], exp_cyc.size());
        end
      end
      if (drain_req && !drained) begin
        chk("ready_wait_timeouts", n_tmo, 32'd0);
        drained = 1'b1;
      end
    end
  end

  task automatic issue(input bit we, input logic [AW+1:0] addr, input logic [1:0] size,
                       input bit uns, input logic [31:0] wdata,
                       input logic [31:0] exp_d, input bit exp_e);
    int w = 0;
    while (!(&rdy_v) && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 200) n_tmo++;
    d_valid = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_size  = size;
    d_uns   = uns;
    d_wdata = wdata;
    exp_cyc.push_back(cyc);
    exp_dat.push_back(exp_d);
    exp_err.push_back(exp_e);
    @(posedge clk);
    #1;
    d_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; d_valid = 1'b0; d_we = 1'b0; d_addr = '0;
    d_size = 2'b00; d_uns = 1'b0; d_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // fields: we, addr, size, unsigned, wdata, expected rdata, expected err
    issue(0, 6'h3C, 2'b10, 0, 32'h0,        32'h00000000, 0);
    issue(1, 6'h08, 2'b10, 0, 32'h11223344, 32'h00000000, 0);
    issue(1, 6'h09, 2'b00, 0, 32'hFFFFFFAB, 32'h00000000, 0);
    issue(0, 6'h08, 2'b10, 0, 32'h0,        32'h1122AB44, 0);
    issue(0, 6'h09, 2'b00, 0, 32'h0,        32'hFFFFFFAB, 0);
    issue(0, 6'h09, 2'b00, 1, 32'h0,        32'h000000AB, 0);
    issue(0, 6'h08, 2'b10, 1, 32'h0,        32'h1122AB44, 0);
    issue(0, 6'h08, 2'b00, 0, 32'h0,        32'h00000044, 0);
    issue(0, 6'h0A, 2'b01, 0, 32'h0,        32'h00001122, 0);
    idle(3);

    issue(1, 6'h0C, 2'b10, 0, 32'hCAFEF00D, 32'h00000000, 0);
    issue(1, 6'h0E, 2'b01, 0, 32'h12348001, 32'h00000000, 0);
    issue(0, 6'h0E, 2'b01, 0, 32'h0,        32'hFFFF8001, 0);
    issue(0, 6'h0E, 2'b01, 1, 32'h0,        32'h00008001, 0);
    issue(0, 6'h0C, 2'b10, 0, 32'h0,        32'h8001F00D, 0);
    issue(0, 6'h0F, 2'b00, 0, 32'h0,        32'hFFFFFF80, 0);
    issue(0, 6'h0C, 2'b01, 0, 32'h0,        32'hFFFFF00D, 0);
    idle(2);

    issue(1, 6'h04, 2'b10, 0, 32'h55667788, 32'h00000000, 0);
    issue(1, 6'h05, 2'b10, 0, 32'hDEADBEEF, 32'h00000000, 1);
    issue(1, 6'h03, 2'b01, 0, 32'hDEADBEEF, 32'h00000000, 1);
    issue(1, 6'h04, 2'b11, 0, 32'hDEADBEEF, 32'h00000000, 1);
    issue(0, 6'h01, 2'b01, 0, 32'h0,        32'h00000000, 1);
    issue(0, 6'h10, 2'b11, 0, 32'h0,        32'h00000000, 1);
    issue(0, 6'h06, 2'b10, 0, 32'h0,        32'h00000000, 1);
    issue(0, 6'h04, 2'b10, 0, 32'h0,        32'h55667788, 0);
    issue(0, 6'h00, 2'b10, 0, 32'h0,        32'h00000000, 0);
    issue(0, 6'h07, 2'b00, 1, 32'h0,        32'h00000055, 0);
    idle(6);

    // Two loads in flight, then reset with a store presented in the reset cycle.
    issue(0, 6'h08, 2'b10, 0, 32'h0,        32'h1122AB44, 0);
    issue(0, 6'h0C, 2'b10, 0, 32'h0,        32'h8001F00D, 0);
    rst = 1'b1; d_valid = 1'b1; d_we = 1'b1; d_addr = 6'h08;
    d_size = 2'b10; d_wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    rst = 1'b0; d_valid = 1'b0; d_we = 1'b0;

    issue(0, 6'h08, 2'b10, 0, 32'h0,        32'h00000000, 0);
    issue(0, 6'h0C, 2'b10, 0, 32'h0,        32'h00000000, 0);
    issue(0, 6'h04, 2'b10, 0, 32'h0,        32'h00000000, 0);
    issue(0, 6'h3C, 2'b10, 0, 32'h0,        32'h00000000, 0);
    idle(8);

    drain_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
